// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - multi-cycle signed ALU with valid/ready handshakes
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   in_valid, in_ready   operation handshake; a/b/command captured on accept
//   a, b                 signed WIDTH-bit operands
//   command              0 ADD, 1 SUB, 2 AND, 3 MUL_LO, 4 MUL_HI, 5 REM, 6 QUO, 7 XOR
//   out_valid, out_ready result handshake; res and flags held until taken
//   res                  WIDTH-bit result
//   zero, overflow, div_by_zero  status flags registered with res
module seq_alu #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       command,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             zero,
    output logic             overflow,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_ADD    = 3'd0;
    localparam logic [2:0] OP_SUB    = 3'd1;
    localparam logic [2:0] OP_AND    = 3'd2;
    localparam logic [2:0] OP_MUL_LO = 3'd3;
    localparam logic [2:0] OP_MUL_HI = 3'd4;
    localparam logic [2:0] OP_REM    = 3'd5;
    localparam logic [2:0] OP_QUO    = 3'd6;
    localparam logic [2:0] OP_XOR    = 3'd7;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t state, state_next;

    logic [CW-1:0]      cnt;
    logic [2:0]         cmd_q;
    logic               sa, sb;
    logic [WIDTH-1:0]   ma, mb;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   rem_r, quo_r;

    logic               accept;
    logic               last_iter;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH-1:0]   sum, diff;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_next, full_prod;
    logic [WIDTH:0]     shifted, trial;
    logic               ge;
    logic [WIDTH-1:0]   rem_next, quo_next, quo_fin, rem_fin;

    logic               load;
    logic [WIDTH-1:0]   nres;
    logic               novf, ndbz;

    assign accept    = in_valid && in_ready;
    assign last_iter = (cnt == CW'(1));

    // Magnitudes are held unsigned so |MIN| = 2^(WIDTH-1) is representable.
    assign abs_a = a[WIDTH-1] ? (~a + 1'b1) : a;
    assign abs_b = b[WIDTH-1] ? (~b + 1'b1) : b;
    assign sum   = a + b;
    assign diff  = a - b;

    // Shift-add multiply: low half holds the multiplier, high half accumulates.
    assign mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, ma} : '0);
    assign prod_next = {mul_sum, prod[WIDTH-1:1]};
    assign full_prod = (sa ^ sb) ? (~prod_next + 1'b1) : prod_next;

    // Restoring divide: quo_r starts as the dividend and is shifted out into rem_r.
    assign shifted  = {rem_r, quo_r[WIDTH-1]};
    assign trial    = shifted - {1'b0, mb};
    assign ge       = !trial[WIDTH];
    assign rem_next = ge ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quo_next = {quo_r[WIDTH-2:0], ge};
    assign quo_fin  = (sa ^ sb) ? (~quo_next + 1'b1) : quo_next;
    assign rem_fin  = sa ? (~rem_next + 1'b1) : rem_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    case (command)
                        OP_MUL_LO, OP_MUL_HI: state_next = S_MUL;
                        OP_REM, OP_QUO:       state_next = (b != '0) ? S_DIV : S_DONE;
                        default:              state_next = S_DONE;
                    endcase
                end
            end
            S_MUL, S_DIV: begin
                if (last_iter) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == S_IDLE) && !reset;
        out_valid = (state == S_DONE);
    end

    // Selects the value to register into res/flags on the edge entering DONE.
    always_comb begin
        load = 1'b0;
        nres = '0;
        novf = 1'b0;
        ndbz = 1'b0;
        case (state)
            S_IDLE: begin
                load = accept && (state_next == S_DONE);
                case (command)
                    OP_ADD: begin
                        nres = sum;
                        novf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
                    end
                    OP_SUB: begin
                        nres = diff;
                        novf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
                    end
                    OP_AND: nres = a & b;
                    OP_XOR: nres = a ^ b;
                    OP_REM: begin
                        nres = a;
                        ndbz = 1'b1;
                    end
                    OP_QUO: begin
                        nres = '1;
                        ndbz = 1'b1;
                    end
                    default: nres = '0;
                endcase
            end
            S_MUL: begin
                load = last_iter;
                if (cmd_q == OP_MUL_LO) begin
                    nres = full_prod[WIDTH-1:0];
                    novf = full_prod[2*WIDTH-1:WIDTH] != {WIDTH{full_prod[WIDTH-1]}};
                end else begin
                    nres = full_prod[2*WIDTH-1:WIDTH];
                end
            end
            S_DIV: begin
                load = last_iter;
                if (cmd_q == OP_QUO) begin
                    nres = quo_fin;
                    // Only MIN / -1 yields a positive quotient with the top bit set.
                    novf = !(sa ^ sb) && quo_next[WIDTH-1];
                end else begin
                    nres = rem_fin;
                end
            end
            default: load = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            cmd_q       <= '0;
            sa          <= 1'b0;
            sb          <= 1'b0;
            ma          <= '0;
            mb          <= '0;
            prod        <= '0;
            rem_r       <= '0;
            quo_r       <= '0;
            res         <= '0;
            zero        <= 1'b0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            if (accept) begin
                cmd_q <= command;
                sa    <= a[WIDTH-1];
                sb    <= b[WIDTH-1];
                ma    <= abs_a;
                mb    <= abs_b;
                cnt   <= CW'(WIDTH);
                prod  <= {{WIDTH{1'b0}}, abs_b};
                rem_r <= '0;
                quo_r <= abs_a;
            end else if (state == S_MUL) begin
                prod <= prod_next;
                cnt  <= cnt - CW'(1);
            end else if (state == S_DIV) begin
                rem_r <= rem_next;
                quo_r <= quo_next;
                cnt   <= cnt - CW'(1);
            end
            if (load) begin
                res         <= nres;
                zero        <= (nres == '0);
                overflow    <= novf;
                div_by_zero <= ndbz;
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - self-checking bench for seq_alu at WIDTH 16, 8 and 32
module tb_seq_alu;

    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, MLO = 3'd3,
                           MHI = 3'd4, REM = 3'd5, QUO = 3'd6, XOR_ = 3'd7;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
    logic [15:0] a = '0, b = '0, res;
    logic [2:0]  command = '0;
    logic        zero, overflow, div_by_zero;

    logic        in_valid_8 = 1'b0, in_ready_8, out_valid_8, out_ready_8 = 1'b1;
    logic [7:0]  a_8 = '0, b_8 = '0, res_8;
    logic [2:0]  command_8 = '0;
    logic        zero_8, overflow_8, div_by_zero_8;

    logic        in_valid_32 = 1'b0, in_ready_32, out_valid_32, out_ready_32 = 1'b1;
    logic [31:0] a_32 = '0, b_32 = '0, res_32;
    logic [2:0]  command_32 = '0;
    logic        zero_32, overflow_32, div_by_zero_32;

    seq_alu #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .command(command), .out_valid(out_valid), .out_ready(out_ready),
        .res(res), .zero(zero), .overflow(overflow), .div_by_zero(div_by_zero)
    );

    seq_alu #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid_8), .in_ready(in_ready_8),
        .a(a_8), .b(b_8), .command(command_8), .out_valid(out_valid_8), .out_ready(out_ready_8),
        .res(res_8), .zero(zero_8), .overflow(overflow_8), .div_by_zero(div_by_zero_8)
    );

    seq_alu #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .in_valid(in_valid_32), .in_ready(in_ready_32),
        .a(a_32), .b(b_32), .command(command_32), .out_valid(out_valid_32), .out_ready(out_ready_32),
        .res(res_32), .zero(zero_32), .overflow(overflow_32), .div_by_zero(div_by_zero_32)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  cmd;
        logic [15:0] r;
        logic        z;
        logic        o;
        logic        d;
        int          lat;
    } vec_t;

    vec_t vecs[17];
    int   tests = 0;
    int   failed = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_ready16(output bit ok);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        ok = in_ready;
    endtask

    task automatic do_op16(input logic [15:0] av, input logic [15:0] bv, input logic [2:0] cv,
                           output logic [15:0] r, output logic z, output logic o,
                           output logic d, output int lat);
        bit ok;
        wait_ready16(ok);
        a = av; b = bv; command = cv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = ~av; b = ~bv; command = ~cv;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        r = res; z = zero; o = overflow; d = div_by_zero;
        @(posedge clk); #1;
    endtask

    task automatic model(input int w, input longint av, input longint bv, input logic [2:0] cmd,
                         output longint r, output logic ovf, output logic dbz);
        longint mn, mx, mask, t;
        mn = -(longint'(1) <<< (w - 1));
        mx = (longint'(1) <<< (w - 1)) - 1;
        mask = (longint'(1) <<< w) - 1;
        ovf = 1'b0;
        dbz = 1'b0;
        t = 0;
        case (cmd)
            ADD:  begin t = av + bv; ovf = (t > mx) || (t < mn); end
            SUB:  begin t = av - bv; ovf = (t > mx) || (t < mn); end
            AND_: t = av & bv;
            XOR_: t = av ^ bv;
            MLO:  begin t = av * bv; ovf = (t > mx) || (t < mn); end
            MHI:  t = (av * bv) >>> w;
            REM:  if (bv == 0) begin t = av; dbz = 1'b1; end else t = av % bv;
            default: if (bv == 0) begin t = -1; dbz = 1'b1; end
                     else begin t = av / bv; ovf = t > mx; end
        endcase
        r = t & mask;
    endtask

    function automatic longint pick(input int w);
        case ($urandom_range(0, 5))
            0: return 0;
            1: return 1;
            2: return -1;
            3: return -(longint'(1) <<< (w - 1));
            4: return (longint'(1) <<< (w - 1)) - 1;
            default: return (w == 8) ? longint'($signed(8'($urandom))) : longint'($signed(32'($urandom)));
        endcase
    endfunction

    task automatic run_rand(input int w, input int idx);
        longint av, bv, exp_r, got_r;
        logic [2:0] cv;
        logic exp_o, exp_d, got_o, got_d, got_z;
        int n;
        bit seen;
        av = pick(w);
        bv = pick(w);
        cv = 3'($urandom_range(0, 7));
        model(w, av, bv, cv, exp_r, exp_o, exp_d);
        n = 0;
        while (!((w == 8) ? in_ready_8 : in_ready_32) && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (w == 8) begin
            a_8 = av[7:0]; b_8 = bv[7:0]; command_8 = cv; in_valid_8 = 1'b1;
        end else begin
            a_32 = av[31:0]; b_32 = bv[31:0]; command_32 = cv; in_valid_32 = 1'b1;
        end
        @(posedge clk); #1;
        in_valid_8 = 1'b0;
        in_valid_32 = 1'b0;
        n = 0;
        while (!((w == 8) ? out_valid_8 : out_valid_32) && n < 100) begin
            @(posedge clk); #1; n++;
        end
        seen = (w == 8) ? out_valid_8 : out_valid_32;
        got_r = (w == 8) ? longint'({56'b0, res_8}) : longint'({32'b0, res_32});
        got_o = (w == 8) ? overflow_8 : overflow_32;
        got_d = (w == 8) ? div_by_zero_8 : div_by_zero_32;
        got_z = (w == 8) ? zero_8 : zero_32;
        chk($sformatf("w%0d #%0d op%0d a=%0d b=%0d valid", w, idx, cv, av, bv), longint'(seen), 1);
        chk($sformatf("w%0d #%0d op%0d a=%0d b=%0d res", w, idx, cv, av, bv), got_r, exp_r);
        chk($sformatf("w%0d #%0d overflow", w, idx), longint'(got_o), longint'(exp_o));
        chk($sformatf("w%0d #%0d div_by_zero", w, idx), longint'(got_d), longint'(exp_d));
        chk($sformatf("w%0d #%0d zero", w, idx), longint'(got_z), longint'(exp_r == 0));
        @(posedge clk); #1;
    endtask

    initial begin
        logic [15:0] r;
        logic z, o, d;
        int lat, nv;

        vecs[0]  = '{16'h7FFF, 16'h0001, ADD,  16'h8000, 1'b0, 1'b1, 1'b0, 1};
        vecs[1]  = '{16'h0005, 16'h0005, SUB,  16'h0000, 1'b1, 1'b0, 1'b0, 1};
        vecs[2]  = '{16'hFFFD, 16'h0005, MLO,  16'hFFF1, 1'b0, 1'b0, 1'b0, 17};
        vecs[3]  = '{16'hFFFD, 16'h0005, MHI,  16'hFFFF, 1'b0, 1'b0, 1'b0, 17};
        vecs[4]  = '{16'h4000, 16'h0004, MLO,  16'h0000, 1'b1, 1'b1, 1'b0, 17};
        vecs[5]  = '{16'h4000, 16'h0004, MHI,  16'h0001, 1'b0, 1'b0, 1'b0, 17};
        vecs[6]  = '{16'hFFF9, 16'h0002, QUO,  16'hFFFD, 1'b0, 1'b0, 1'b0, 17};
        vecs[7]  = '{16'hFFF9, 16'h0002, REM,  16'hFFFF, 1'b0, 1'b0, 1'b0, 17};
        vecs[8]  = '{16'h8000, 16'hFFFF, QUO,  16'h8000, 1'b0, 1'b1, 1'b0, 17};
        vecs[9]  = '{16'h8000, 16'hFFFF, REM,  16'h0000, 1'b1, 1'b0, 1'b0, 17};
        vecs[10] = '{16'h0005, 16'h0000, QUO,  16'hFFFF, 1'b0, 1'b0, 1'b1, 1};
        vecs[11] = '{16'h0005, 16'h0000, REM,  16'h0005, 1'b0, 1'b0, 1'b1, 1};
        vecs[12] = '{16'hF0F0, 16'h3C3C, AND_, 16'h3030, 1'b0, 1'b0, 1'b0, 1};
        vecs[13] = '{16'hF0F0, 16'hF0F0, XOR_, 16'h0000, 1'b1, 1'b0, 1'b0, 1};
        vecs[14] = '{16'h8000, 16'h0001, SUB,  16'h7FFF, 1'b0, 1'b1, 1'b0, 1};
        vecs[15] = '{16'h8000, 16'h8000, MLO,  16'h0000, 1'b1, 1'b1, 1'b0, 17};
        vecs[16] = '{16'h7FFF, 16'h8000, REM,  16'h7FFF, 1'b0, 1'b0, 1'b0, 17};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready", longint'(in_ready), 0);
        chk("reset out_valid", longint'(out_valid), 0);
        chk("reset res", longint'(res), 0);
        chk("reset flags", longint'({zero, overflow, div_by_zero}), 0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post-reset in_ready", longint'(in_ready), 1);

        // Directed vectors.
        for (int i = 0; i < 17; i++) begin
            do_op16(vecs[i].a, vecs[i].b, vecs[i].cmd, r, z, o, d, lat);
            chk($sformatf("vec%0d latency", i), longint'(lat), longint'(vecs[i].lat));
            chk($sformatf("vec%0d res", i), longint'(r), longint'(vecs[i].r));
            chk($sformatf("vec%0d zero", i), longint'(z), longint'(vecs[i].z));
            chk($sformatf("vec%0d overflow", i), longint'(o), longint'(vecs[i].o));
            chk($sformatf("vec%0d div_by_zero", i), longint'(d), longint'(vecs[i].d));
        end

        // Result backpressure: held output, no new accept.
        out_ready = 1'b0;
        a = 16'h0001; b = 16'h0002; command = ADD; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp out_valid k+1", longint'(out_valid), 1);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                a = 16'h0009; b = 16'h0009; command = SUB; in_valid = 1'b1;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk($sformatf("bp hold%0d res", i), longint'(res), 3);
            chk($sformatf("bp hold%0d valid/ready/flags", i),
                longint'({out_valid, in_ready, zero, overflow, div_by_zero}), longint'(5'b10000));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp release out_valid", longint'(out_valid), 0);
        chk("bp release in_ready", longint'(in_ready), 1);
        chk("bp release res held", longint'(res), 3);
        @(posedge clk); #1;
        chk("bp dropped pulse not accepted", longint'(out_valid), 0);

        // Reset in the middle of a multiply.
        a = 16'h0003; b = 16'h0005; command = MLO; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midreset out_valid", longint'(out_valid), 0);
        chk("midreset res", longint'(res), 0);
        chk("midreset in_ready", longint'(in_ready), 0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("after reset in_ready", longint'(in_ready), 1);
        nv = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) nv++;
        end
        chk("no stale result", longint'(nv), 0);
        chk("res still cleared", longint'(res), 0);

        // Randomized operands at WIDTH 8 and 32 against the reference model.
        for (int i = 0; i < 24; i++) run_rand(8, i);
        for (int i = 0; i < 24; i++) run_rand(32, i);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
